wc_io_gearbox: RTL and testbench

Pad-side width gearbox between the chip I/O ring and the Winograd core (WC). It is the parametrised successor to the flat full-width pad wrapper and cuts pad count. Operand elements arrive over a DW-bit input lane, one element per beat, and are assembled into the N_IN-element operand vector for the core. The core's N_OUT-element result vector is captured and serialised back out over a DW-bit output lane with a valid/ready handshake.

---
 rtl/wc_pkg.sv | 16 +
 rtl/wc_ser.sv | 68 ++++++
 rtl/wc_io_gearbox.sv | 99 +++++++++
 tb/tb_wc_io_gearbox.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
// rtl/wc_pkg.sv - shared defaults, FSM state types and counter-width helper for the WC I/O gearbox
package wc_pkg;

  localparam int WC_DW    = 10;
  localparam int WC_N_IN  = 5;
  localparam int WC_N_OUT = 3;

  typedef enum logic {FILL, HOLD} in_state_t;
  typedef enum logic {IDLE, SEND} out_state_t;

  // Element counters index 0..n-1; a single-slot vector still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wc_ser.sv
// rtl/wc_ser.sv - generic parallel-to-serial stage: captures an N-element vector, streams it out one element per beat
module wc_ser
  import wc_pkg::*;
#(
  parameter int DW = WC_DW,
  parameter int N  = WC_N_OUT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [DW*N-1:0] par_data_i,
  input  logic            par_vld_i,
  output logic            par_rdy_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i
);

  localparam int CW = cnt_w(N);

  out_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW*N-1:0] shadow_q, shadow_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    par_rdy_o  = (state_q == IDLE);
    m_tvalid_o = (state_q == SEND);
    m_tdata_o  = '0;

    case (state_q)
      IDLE: begin
        if (par_vld_i) begin
          shadow_d = par_data_i;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // The shadow copy frees the core immediately; data only moves on a handshake.
        m_tdata_o = shadow_q[cnt_q*DW +: DW];
        if (m_tready_i) begin
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/wc_io_gearbox.sv
// rtl/wc_io_gearbox.sv - pad-side gearbox: assembles operand vectors from a DW lane, serialises result vectors back out
module wc_io_gearbox
  import wc_pkg::*;
#(
  parameter int DW    = WC_DW,
  parameter int N_IN  = WC_N_IN,
  parameter int N_OUT = WC_N_OUT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DW-1:0]       in_data_i,
  input  logic                in_sof_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DW*N_IN-1:0]  d_vec_o,
  output logic                d_vld_o,
  input  logic                d_rdy_i,
  input  logic [DW*N_OUT-1:0] z_vec_i,
  input  logic                z_vld_i,
  output logic                z_rdy_o,
  output logic [DW-1:0]       out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                sync_err_o
);

  localparam int CIW = cnt_w(N_IN);

  in_state_t          in_state_q, in_state_d;
  logic [CIW-1:0]     cnt_in_q, cnt_in_d;
  logic [CIW-1:0]     slot;
  logic [DW*N_IN-1:0] d_vec_q, d_vec_d;
  logic               sync_err_q, sync_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_state_q <= FILL;
      cnt_in_q   <= '0;
      d_vec_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      cnt_in_q   <= cnt_in_d;
      d_vec_q    <= d_vec_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    cnt_in_d   = cnt_in_q;
    d_vec_d    = d_vec_q;
    sync_err_d = sync_err_q;
    in_ready_o = (in_state_q == FILL);
    d_vld_o    = (in_state_q == HOLD);
    // A start-of-frame resynchronises to slot 0 and abandons any partial vector.
    slot       = in_sof_i ? '0 : cnt_in_q;

    case (in_state_q)
      FILL: begin
        if (in_valid_i) begin
          d_vec_d[slot*DW +: DW] = in_data_i;
          if (in_sof_i && (cnt_in_q != '0)) sync_err_d = 1'b1;
          if (slot == CIW'(N_IN - 1)) begin
            cnt_in_d   = '0;
            in_state_d = HOLD;
          end else begin
            cnt_in_d = slot + 1'b1;
          end
        end
      end
      HOLD: begin
        if (d_rdy_i) begin
          cnt_in_d   = '0;
          in_state_d = FILL;
        end
      end
      default: in_state_d = FILL;
    endcase
  end

  assign d_vec_o    = d_vec_q;
  assign sync_err_o = sync_err_q;

  wc_ser #(
    .DW (DW),
    .N  (N_OUT)
  ) u_ser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .par_data_i (z_vec_i),
    .par_vld_i  (z_vld_i),
    .par_rdy_o  (z_rdy_o),
    .m_tdata_o  (out_data_o),
    .m_tvalid_o (out_valid_o),
    .m_tready_i (out_ready_i)
  );

endmodule

// File: tb/tb_wc_io_gearbox.sv
// tb/tb_wc_io_gearbox.sv - directed self-checking bench for wc_io_gearbox
module tb_wc_io_gearbox;

  localparam int DW = 10;
  localparam int NI = 5;
  localparam int NO = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    in_data;
  logic             in_sof, in_valid, in_ready;
  logic [DW*NI-1:0] d_vec;
  logic             d_vld, d_rdy;
  logic [DW*NO-1:0] z_vec;
  logic             z_vld, z_rdy;
  logic [DW-1:0]    out_data;
  logic             out_valid, out_ready, sync_err;

  int checks = 0;
  int errors = 0;

  wc_io_gearbox #(.DW(DW), .N_IN(NI), .N_OUT(NO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (in_data),
    .in_sof_i    (in_sof),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .d_vec_o     (d_vec),
    .d_vld_o     (d_vld),
    .d_rdy_i     (d_rdy),
    .z_vec_i     (z_vec),
    .z_vld_i     (z_vld),
    .z_rdy_o     (z_rdy),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sync_err_o  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*NI-1:0] pk5(input int a, input int b, input int c, input int d, input int e);
    return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Drive one element so that it is taken on the coming rising edge.
  task automatic push(input int val, input logic sof);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("push_rdy", in_ready, 1'b1);
    in_data  = DW'(val);
    in_sof   = sof;
    in_valid = 1'b1;
  endtask

  task automatic end_push();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_d_vld"}, d_vld, 1'b0);
    check({tag, "_d_vec"}, d_vec, '0);
    check({tag, "_z_rdy"}, z_rdy, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_sync_err"}, sync_err, 1'b0);
  endtask

  logic [DW-1:0] exp_out [NO];
  logic          rdy_pat [6];

  initial begin
    int idx;
    rst_n = 1'b0; in_data = '0; in_sof = 1'b0; in_valid = 1'b0;
    d_rdy = 1'b1; z_vec = '0; z_vld = 1'b0; out_ready = 1'b1;
    exp_out[0] = 10'h2AA; exp_out[1] = 10'h155; exp_out[2] = 10'h3FF;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
    rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Basic assembly with d_rdy tied high: HOLD lasts exactly one cycle.
    push(1, 1'b1);
    for (int i = 2; i <= 5; i++) push(i, 1'b0);
    end_push();
    check("v1_d_vec", d_vec, pk5(1, 2, 3, 4, 5));
    check("v1_d_vld", d_vld, 1'b1);
    check("v1_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("v1_d_vld_drop", d_vld, 1'b0);
    check("v1_in_ready_back", in_ready, 1'b1);

    // Backpressure from the core: vector held, then next element taken right after release.
    d_rdy = 1'b0;
    for (int i = 21; i <= 25; i++) push(i, 1'b0);
    end_push();
    in_data = DW'(30); in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_d_vld", d_vld, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_d_vec", d_vec, pk5(21, 22, 23, 24, 25));
    end
    d_rdy = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_d_vld", d_vld, 1'b0);
    for (int i = 31; i <= 34; i++) push(i, 1'b0);
    end_push();
    check("rel_d_vec", d_vec, pk5(30, 31, 32, 33, 34));
    check("rel_sync_err", sync_err, 1'b0);

    // Mid-vector SOF: partial 7,8 dropped, error latched and sticky.
    push(7, 1'b0);
    push(8, 1'b0);
    push(9, 1'b1);
    for (int i = 10; i <= 13; i++) push(i, 1'b0);
    end_push();
    check("sof_d_vec", d_vec, pk5(9, 10, 11, 12, 13));
    check("sof_sync_err", sync_err, 1'b1);
    for (int i = 1; i <= 5; i++) push(i + 60, 1'b0);
    end_push();
    check("clean_d_vec", d_vec, pk5(61, 62, 63, 64, 65));
    check("sticky_sync_err", sync_err, 1'b1);

    // Serialiser with an always-ready sink.
    z_vec = {10'h3FF, 10'h155, 10'h2AA};
    out_ready = 1'b1;
    @(negedge clk);
    check("ser_z_rdy_idle", z_rdy, 1'b1);
    z_vld = 1'b1;
    @(negedge clk);
    z_vld = 1'b0;
    for (int k = 0; k < NO; k++) begin
      if (k > 0) @(negedge clk);
      check("ser_valid", out_valid, 1'b1);
      check("ser_data", out_data, exp_out[k]);
      check("ser_z_rdy", z_rdy, 1'b0);
    end
    @(negedge clk);
    check("ser_done_valid", out_valid, 1'b0);
    check("ser_done_z_rdy", z_rdy, 1'b1);

    // Serialiser with a stalling sink.
    z_vld = 1'b1;
    @(negedge clk);
    z_vld = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, exp_out[idx]);
      out_ready = rdy_pat[k];
      if (rdy_pat[k]) idx++;
    end
    @(negedge clk);
    check("stall_done_valid", out_valid, 1'b0);
    check("stall_count", idx, NO);
    out_ready = 1'b1;

    // Asynchronous reset with both halves busy.
    out_ready = 1'b0;
    z_vld = 1'b1;
    push(41, 1'b0);
    z_vld = 1'b0;
    push(42, 1'b0);
    push(43, 1'b0);
    end_push();
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_d_vec", d_vec, pk5(41, 42, 43, 0, 0) | (d_vec & {{(2*DW){1'b1}}, {(3*DW){1'b0}}}));
    #2 rst_n = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 51; i <= 55; i++) push(i, 1'b0);
    end_push();
    check("post_rst_d_vec", d_vec, pk5(51, 52, 53, 54, 55));
    check("post_rst_d_vld", d_vld, 1'b1);
    check("post_rst_sync_err", sync_err, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
